// File: rtl/vector_writeback_unit.sv
// Vector writeback unit: buffers execution results in a FIFO and serializes them into BANK_WIDTH-wide VRF writes.
// Pushes are accepted while the FIFO is not full; the bypass register is built only when VWB_BYPASS_EN is defined.
module vector_writeback_unit #(
  parameter int VLEN       = 128,
  parameter int BANK_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int BEATS     = VLEN / BANK_WIDTH,
  localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_vd,
  input  logic [VLEN-1:0]         in_data,
  input  logic [VLEN/8-1:0]       in_be,
  output logic                    vrf_we,
  output logic [4:0]              vrf_addr,
  output logic [BW-1:0]           vrf_beat,
  output logic [BANK_WIDTH-1:0]   vrf_wdata,
  output logic [BANK_WIDTH/8-1:0] vrf_wbe,
  output logic                    wb_done,
  output logic [4:0]              wb_done_vd,
  output logic                    bypass_valid,
  output logic [4:0]              bypass_vd,
  output logic [VLEN-1:0]         bypass_data,
  output logic                    busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BB = BANK_WIDTH / 8;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t state_q, state_d;

  logic [4:0]        fifo_vd   [FIFO_DEPTH];
  logic [VLEN-1:0]   fifo_data [FIFO_DEPTH];
  logic [VLEN/8-1:0] fifo_be   [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;

  logic [4:0]        h_vd;
  logic [VLEN-1:0]   h_data;
  logic [VLEN/8-1:0] h_be;
  logic [BW-1:0]     cnt;

  logic fifo_empty, fifo_full, push, pop, last_beat;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  // Gated by reset_n so in_ready reads 0 while reset is held.
  assign in_ready   = reset_n && !fifo_full;
  assign push       = in_valid && !fifo_full && !flush;
  assign last_beat  = (cnt == BW'(BEATS-1));
  assign busy       = !fifo_empty || (state_q == WRITE);

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    vrf_we     = 1'b0;
    vrf_addr   = '0;
    vrf_beat   = '0;
    vrf_wdata  = '0;
    vrf_wbe    = '0;
    wb_done    = 1'b0;
    wb_done_vd = '0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        vrf_we    = 1'b1;
        vrf_addr  = h_vd;
        vrf_beat  = cnt;
        vrf_wdata = h_data[int'(cnt)*BANK_WIDTH +: BANK_WIDTH];
        vrf_wbe   = h_be[int'(cnt)*BB +: BB];
        if (last_beat) begin
          wb_done    = 1'b1;
          wb_done_vd = h_vd;
          if (!fifo_empty) pop = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      pop     = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt     <= '0;
      h_vd    <= '0;
      h_data  <= '0;
      h_be    <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        cnt <= '0;
      end else if (pop) begin
        cnt    <= '0;
        h_vd   <= fifo_vd[rd_ptr];
        h_data <= fifo_data[rd_ptr];
        h_be   <= fifo_be[rd_ptr];
      end else if (state_q == WRITE) begin
        cnt <= cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_vd[i]   <= '0;
        fifo_data[i] <= '0;
        fifo_be[i]   <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_vd[wr_ptr]   <= in_vd;
        fifo_data[wr_ptr] <= in_data;
        fifo_be[wr_ptr]   <= in_be;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

`ifdef VWB_BYPASS_EN
  // An accept in the same cycle as the matching wb_done keeps the bypass alive.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bypass_valid <= 1'b0;
      bypass_vd    <= '0;
      bypass_data  <= '0;
    end else if (flush) begin
      bypass_valid <= 1'b0;
    end else if (push) begin
      bypass_valid <= 1'b1;
      bypass_vd    <= in_vd;
      bypass_data  <= in_data;
    end else if (wb_done && (wb_done_vd == bypass_vd) && fifo_empty) begin
      bypass_valid <= 1'b0;
    end
  end
`else
  assign bypass_valid = 1'b0;
  assign bypass_vd    = '0;
  assign bypass_data  = '0;
`endif

endmodule

// File: tb/tb_vector_writeback_unit.sv
// Directed bench for vector_writeback_unit (VLEN=128, BANK_WIDTH=32, FIFO_DEPTH=4).
module tb_vector_writeback_unit;

  logic         clock = 1'b0;
  logic         reset_n, flush, in_valid, in_ready;
  logic [4:0]   in_vd;
  logic [127:0] in_data;
  logic [15:0]  in_be;
  logic         vrf_we, wb_done, bypass_valid, busy;
  logic [4:0]   vrf_addr, wb_done_vd, bypass_vd;
  logic [1:0]   vrf_beat;
  logic [31:0]  vrf_wdata;
  logic [3:0]   vrf_wbe;
  logic [127:0] bypass_data;

  int tests = 0;
  int fails = 0;

  vector_writeback_unit #(.VLEN(128), .BANK_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_vd(in_vd), .in_data(in_data), .in_be(in_be),
    .vrf_we(vrf_we), .vrf_addr(vrf_addr), .vrf_beat(vrf_beat), .vrf_wdata(vrf_wdata), .vrf_wbe(vrf_wbe),
    .wb_done(wb_done), .wb_done_vd(wb_done_vd),
    .bypass_valid(bypass_valid), .bypass_vd(bypass_vd), .bypass_data(bypass_data),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] b2b_data(input int k);
    logic [127:0] d;
    for (int b = 0; b < 4; b++) d[b*32 +: 32] = {8'(k), 8'(b), 16'hABCD};
    return d;
  endfunction

  initial begin
    int k, nw, gaps, first_full, timeout;
    logic rdy_b, seen9;
    logic [31:0] exp_w;
    logic [127:0] d;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_vd = '0; in_data = '0; in_be = '0;
    #12;
    chk("rst_vrf_we", vrf_we, 0);
    chk("rst_wb_done", wb_done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bypass_valid", bypass_valid, 0);
    chk("rst_outs", {vrf_addr, vrf_beat, vrf_wdata, vrf_wbe, wb_done_vd}, 0);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    step();

    // Single packet: 4 beats, accept-to-first-write of 2 cycles.
    in_valid = 1'b1; in_vd = 5'd3;
    in_data = 128'h0F0E0D0C0B0A09080706050403020100; in_be = 16'hFFFF;
    step();
    in_valid = 1'b0;
    chk("single_no_write_t1", vrf_we, 0);
    chk("single_busy", busy, 1);
`ifdef VWB_BYPASS_EN
    chk("single_bypass", {bypass_valid, bypass_vd}, {1'b1, 5'd3});
`endif
    step();
    for (int b = 0; b < 4; b++) begin
      exp_w = {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)};
      chk($sformatf("single_beat%0d", b), {vrf_we, vrf_addr, vrf_beat, vrf_wdata, vrf_wbe},
          {1'b1, 5'd3, 2'(b), exp_w, 4'hF});
      chk($sformatf("single_done%0d", b), {wb_done, wb_done_vd}, (b == 3) ? {1'b1, 5'd3} : 6'd0);
      step();
    end
    chk("single_idle", {vrf_we, busy, bypass_valid}, 0);

    // Byte enables: only beat 1 enabled, all beats still written.
    in_valid = 1'b1; in_vd = 5'd7; in_data = {4{32'h5A5A1234}}; in_be = 16'h00F0;
    step();
    in_valid = 1'b0;
    step();
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("be_beat%0d", b), {vrf_we, vrf_beat, vrf_wbe}, {1'b1, 2'(b), (b == 1) ? 4'hF : 4'h0});
      step();
    end

    // Back-to-back: 6 packets at full rate, 24 gapless writes in order.
    k = 0; nw = 0; gaps = 0; first_full = -1;
    in_valid = 1'b1; in_vd = 5'd10; in_data = b2b_data(0); in_be = 16'hFFFF;
    for (int cyc = 0; cyc < 60; cyc++) begin
      rdy_b = in_ready;
      step();
      if (in_valid && rdy_b) begin
        k++;
        if (k == 6) in_valid = 1'b0;
        else begin in_vd = 5'(10 + k); in_data = b2b_data(k); end
      end
      if (!in_ready && first_full < 0) first_full = k;
      if (vrf_we) begin
        if (nw < 24) begin
          d = b2b_data(nw / 4);
          chk($sformatf("b2b_write%0d", nw), {vrf_addr, vrf_beat, vrf_wdata},
              {5'(10 + nw / 4), 2'(nw % 4), d[(nw % 4)*32 +: 32]});
        end
        nw++;
      end else if (nw > 0 && nw < 24) gaps++;
    end
    chk("b2b_accepted", k, 6);
    chk("b2b_full_after", first_full, 5);
    chk("b2b_total_writes", nw, 24);
    chk("b2b_gaps", gaps, 0);
    chk("b2b_idle", busy, 0);

    // Flush during beat 2 with two packets queued.
    in_be = 16'hFFFF;
    for (int p = 0; p < 3; p++) begin
      in_valid = 1'b1; in_vd = 5'(20 + p); in_data = {4{32'(p)}};
      step();
    end
    in_valid = 1'b0;
    step();
    chk("flush_at_beat2", {vrf_we, vrf_addr, vrf_beat, wb_done}, {1'b1, 5'd20, 2'd2, 1'b0});
    flush = 1'b1; in_valid = 1'b1; in_vd = 5'd30;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_after", {vrf_we, wb_done, busy, bypass_valid, in_ready}, 5'b00001);
    nw = 0;
    for (int c = 0; c < 6; c++) begin
      if (vrf_we || wb_done) nw++;
      step();
    end
    chk("flush_quiet", nw, 0);

    // Bypass: vd=5 then vd=9; valid holds until vd=9 completes with FIFO empty.
    in_valid = 1'b1; in_vd = 5'd5; in_data = {4{32'h55555555}};
    step();
    in_vd = 5'd9; in_data = {4{32'h99999999}};
    step();
    in_valid = 1'b0;
`ifdef VWB_BYPASS_EN
    chk("byp_newest", {bypass_valid, bypass_vd, bypass_data}, {1'b1, 5'd9, {4{32'h99999999}}});
`else
    chk("byp_off_newest", {bypass_valid, bypass_vd, bypass_data}, 0);
`endif
    seen9 = 1'b0; nw = 0; timeout = 0;
    while (!seen9) begin
      if (timeout++ > 20) break;
`ifdef VWB_BYPASS_EN
      if (bypass_valid !== 1'b1) nw++;
`else
      if (bypass_valid !== 1'b0) nw++;
`endif
      if (wb_done && wb_done_vd == 5'd9) seen9 = 1'b1;
      step();
    end
    chk("byp_seen_done9", seen9, 1);
    chk("byp_hold_errors", nw, 0);
    chk("byp_cleared", bypass_valid, 0);

    // Reset asserted mid-WRITE.
    in_valid = 1'b1; in_vd = 5'd12; in_data = {4{32'hC0FFEE00}};
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("rstmid_writing", vrf_we, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_outs", {vrf_we, wb_done, bypass_valid, busy, in_ready}, 0);
    chk("rstmid_data", {vrf_addr, vrf_beat, vrf_wdata, vrf_wbe}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rstmid_ready", in_ready, 1);
    step();
    chk("rstmid_no_state", {vrf_we, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vector_writeback_unit.md
# vector_writeback_unit

Consumer end of the vector execution result path: accepts completed result packets from the vector execution stage, buffers them in a small FIFO, and serializes each VLEN-wide result into BANK_WIDTH-wide beats on the vector register file write port. It also returns the newest accepted result to the execution stage as a bypass packet and pulses a per-register completion event for the scoreboard. It sits between the registered output of the vector execution stage and the VRF; parent glue unpacks and packs `data_packet_t` to and from the flat ports below.

## Interface
- VLEN, 128, result width in bits; multiple of BANK_WIDTH
- BANK_WIDTH, 32, VRF write port width in bits; multiple of 8
- FIFO_DEPTH, 4, result FIFO entries; power of two, ≥2
- Derived: BEATS = VLEN/BANK_WIDTH; BW = max(1, $clog2(BEATS))
- clock  in  1  rising-edge clock
- reset_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort of all buffered and in-flight work
- in_valid  in  1  result packet offered
- in_ready  out  1  FIFO can accept; high when FIFO not full
- in_vd  in  5  destination vector register
- in_data  in  VLEN  result data
- in_be  in  VLEN/8  byte enables
- vrf_we  out  1  VRF write strobe
- vrf_addr  out  5  VRF register index
- vrf_beat  out  BW  beat index within register, 0 = bits [BANK_WIDTH-1:0]
- vrf_wdata  out  BANK_WIDTH  beat data
- vrf_wbe  out  BANK_WIDTH/8  beat byte enables
- wb_done  out  1  one-cycle pulse on a packet's final beat
- wb_done_vd  out  5  register completed; valid while wb_done
- bypass_valid  out  1  bypass packet valid
- bypass_vd  out  5  bypass destination register
- bypass_data  out  VLEN  bypass data
- busy  out  1  FIFO non-empty or FSM in WRITE

## Operation
- Accept: handshake is in_valid && in_ready; packet {vd, data, be} is pushed at that edge. in_ready = !full, computed from the registered count; a same-cycle pop does not raise it.
- FSM states: IDLE and WRITE. IDLE: if the FIFO is non-empty, pop the head into the holding register, clear the beat counter, and go to WRITE. WRITE: vrf_we = 1; vrf_addr = holding vd; vrf_beat = counter; wdata and wbe are the counter slice. The counter increments each cycle.
- Last beat (counter == BEATS-1): wb_done = 1 with wb_done_vd = holding vd. If the FIFO is non-empty, pop and reload at the same edge and stay in WRITE, so there is no bubble. Otherwise go to IDLE.
- Beats with all-zero byte enables are still issued, with vrf_we = 1 and wbe = 0.
- In IDLE, vrf_we, wb_done, and all vrf_* data outputs are 0.
- Bypass register:
  - Loads {vd, data} on every accept and sets bypass_valid.
  - Clears bypass_valid when wb_done fires for bypass_vd, the FIFO is empty, and no accept occurs that cycle.
  - An accept in the same cycle wins.
- flush: at the edge, empties the FIFO, forces IDLE, clears the counter and bypass_valid, and suppresses any accept that cycle. A packet in WRITE is abandoned mid-register with no wb_done. Combinational outputs still reflect the pre-flush state during the flush cycle.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Reset values: every register and every output is 0. in_ready is 1 once out of reset.

## Timing
- A packet accepted at edge t is popped at edge t+1. Beat 0 appears in the cycle after t+1, and the final beat and wb_done appear BEATS-1 cycles later. Accept-to-first-write latency is 2 cycles.
- Throughput is one packet per BEATS cycles. The FIFO absorbs bursts of up to FIFO_DEPTH packets beyond the one in WRITE.
- bypass_* is valid from the cycle after accept, one cycle ahead of the packet's first VRF beat.
- Asserting reset mid-packet immediately drops vrf_we, wb_done, and bypass_valid. No partial state survives.

## Configuration
- VWB_BYPASS_EN defined: the bypass register and the bypass_* outputs operate as described above.
- VWB_BYPASS_EN undefined: the bypass register is not built. bypass_valid, bypass_vd, and bypass_data are tied to 0. All other behaviour is identical.

## Test plan
- Single packet (VLEN=128, BANK_WIDTH=32): accept vd=3, data=0x0F0E…00, be all ones. Expect 4 writes beat 0..3 with wdata 0x03020100, 0x07060504, …. wb_done with vd=3 on beat 3. First write 2 cycles after accept.
- Back-to-back: hold in_valid for 6 packets at full rate. Expect in_ready to fall after 4 are buffered plus 1 in WRITE. Expect exactly 24 consecutive vrf_we cycles with no gap, in input order.
- Byte enables: in_be=0x00F0. Expect beat 1 with wbe=0xF and beats 0, 2, 3 with wbe=0, all with vrf_we=1.
- Flush during beat 2 with 2 packets queued: expect no wb_done, vrf_we=0 next cycle, busy=0, bypass_valid=0, in_ready=1.
- Bypass, with VWB_BYPASS_EN: accept vd=5 then vd=9. Expect bypass_vd=9. Expect bypass_valid to clear only after vd=9 wb_done with the FIFO empty. Without the macro, bypass_valid stays 0 throughout.
- Reset asserted mid-WRITE: expect all outputs 0 asynchronously and in_ready=1 after release.
